// File: rtl/karatsuba_prod_accum_pkg.sv
// Shared definitions for the Karatsuba product column accumulator.
//
// Contents:
//   LIMB_W_DEF / PROD_W_DEF : default limb and product widths (34 / 77)
//   TAG_W                   : width of a delayed operand tag {valid, col_last, frame_last}
//   state_t                 : accumulator control states ACCUM, DRAIN, FLUSH
//   calc_acc_w()            : accumulator width, the product width plus column growth plus one spare bit
//   calc_flush_limbs()      : number of limbs needed to empty the accumulator after the last column
package karatsuba_prod_accum_pkg;

   localparam int LIMB_W_DEF = 34;
   localparam int PROD_W_DEF = 77;
   localparam int TAG_W      = 3;

   typedef enum logic [1:0] {
      ACCUM,
      DRAIN,
      FLUSH
   } state_t;

   // Headroom for MAX_TERMS products plus the carry left over from the previous column.
   function automatic int calc_acc_w(input int prod_w, input int max_terms);
      return prod_w + $clog2(max_terms) + 1;
   endfunction

   // Ceiling division: what is left in the accumulator after one limb has been emitted.
   function automatic int calc_flush_limbs(input int acc_w, input int limb_w);
      return (acc_w - limb_w + limb_w - 1) / limb_w;
   endfunction

endpackage

// File: rtl/karatsuba_tag_delay.sv
// Fixed-depth shift register that carries operand tags alongside the multiplier
// pipeline, so a tag leaves the line in the same cycle as its product.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, clears every stage to 0
//   tag_in  : tag entering the line this cycle
//   tag_out : tag entered DEPTH cycles earlier
module karatsuba_tag_delay
   import karatsuba_prod_accum_pkg::*;
#(
   parameter int DEPTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [TAG_W-1:0] tag_in,
   output logic [TAG_W-1:0] tag_out
);

   logic [DEPTH-1:0][TAG_W-1:0] stages;

   // Clearing every stage on reset drops whatever products were in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stages <= '0;
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/karatsuba_prod_accum.sv
// Column accumulator behind the 34x43 Karatsuba multiplier. It sums all products
// of one output column, emits one LIMB_W-bit limb per column (least significant first)
// and carries the rest forward. At frame end it flushes the carry as FLUSH_LIMBS extra limbs.
// Operand tags are delayed internally by MUL_LAT cycles to line up with the products.
//
// Optional feature: define KARATSUBA_ACC_OVF_CHK_EN to build the per-column term
// counter that drives the sticky ovf flag. Without it, ovf is tied to 0.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   tag_valid      : operand pair issued to the multiplier this cycle
//   tag_col_last   : pair is the last term of its column
//   tag_frame_last : pair is the last term of the frame
//   tag_ready      : upstream may issue only while high
//   prod           : multiplier product, unsigned
//   limb_valid     : one-cycle strobe for limb
//   limb           : emitted limb
//   limb_last      : final limb of the frame
//   ovf            : sticky column-overflow flag
module karatsuba_prod_accum
   import karatsuba_prod_accum_pkg::*;
#(
   parameter int LIMB_W    = LIMB_W_DEF,
   parameter int PROD_W    = PROD_W_DEF,
   parameter int MAX_TERMS = 4,
   parameter int MUL_LAT   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tag_valid,
   input  logic              tag_col_last,
   input  logic              tag_frame_last,
   output logic              tag_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              limb_valid,
   output logic [LIMB_W-1:0] limb,
   output logic              limb_last,
   output logic              ovf
);

   localparam int ACC_W       = calc_acc_w(PROD_W, MAX_TERMS);
   localparam int FLUSH_LIMBS = calc_flush_limbs(ACC_W, LIMB_W);
   localparam int FCNT_W      = (FLUSH_LIMBS > 1) ? $clog2(FLUSH_LIMBS) : 1;

   state_t            state;
   state_t            state_next;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_next;
   logic [ACC_W-1:0]  acc_sum;
   logic [FCNT_W-1:0] flush_cnt;
   logic [FCNT_W-1:0] flush_cnt_next;
   logic              limb_valid_next;
   logic [LIMB_W-1:0] limb_next;
   logic              limb_last_next;

   logic              tag_accept;
   logic [TAG_W-1:0]  tag_in;
   logic [TAG_W-1:0]  tag_out;
   logic              d_valid;
   logic              d_col_last;
   logic              d_frame_last;
   logic              col_end;

   assign tag_ready  = (state == ACCUM);
   assign tag_accept = tag_valid & tag_ready;

   // Refused tags enter the line as all-zero, so their products are never summed.
   assign tag_in = {tag_accept, tag_accept & tag_col_last, tag_accept & tag_frame_last};

   karatsuba_tag_delay #(
      .DEPTH (MUL_LAT)
   ) u_tag_delay (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign d_valid      = tag_out[2];
   assign d_col_last   = tag_out[1];
   assign d_frame_last = tag_out[0];

   // A frame_last tag always closes its column, even if col_last was left low.
   assign col_end = d_valid & (d_col_last | d_frame_last);

   assign acc_sum = acc + {{(ACC_W-PROD_W){1'b0}}, prod};

   // Next-state and datapath. Products of accepted tags are summed in every state;
   // FLUSH never overlaps a delayed product because no tags are taken during DRAIN.
   always_comb begin
      state_next      = state;
      acc_next        = acc;
      flush_cnt_next  = flush_cnt;
      limb_valid_next = 1'b0;
      limb_next       = limb;
      limb_last_next  = 1'b0;

      if (d_valid) begin
         if (col_end) begin
            limb_valid_next = 1'b1;
            limb_next       = acc_sum[LIMB_W-1:0];
            acc_next        = acc_sum >> LIMB_W;
         end else begin
            acc_next = acc_sum;
         end
      end

      case (state)
         ACCUM: begin
            if (tag_accept && tag_frame_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (d_valid && d_frame_last) begin
               state_next     = FLUSH;
               flush_cnt_next = '0;
            end
         end
         FLUSH: begin
            limb_valid_next = 1'b1;
            limb_next       = acc[LIMB_W-1:0];
            acc_next        = acc >> LIMB_W;
            if (flush_cnt == FCNT_W'(FLUSH_LIMBS - 1)) begin
               limb_last_next = 1'b1;
               acc_next       = '0;
               flush_cnt_next = '0;
               state_next     = ACCUM;
            end else begin
               flush_cnt_next = flush_cnt + 1'b1;
            end
         end
         default: begin
            state_next = ACCUM;
         end
      endcase
   end

   // State, accumulator and registered limb outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ACCUM;
         acc        <= '0;
         flush_cnt  <= '0;
         limb_valid <= 1'b0;
         limb       <= '0;
         limb_last  <= 1'b0;
      end else begin
         state      <= state_next;
         acc        <= acc_next;
         flush_cnt  <= flush_cnt_next;
         limb_valid <= limb_valid_next;
         limb       <= limb_next;
         limb_last  <= limb_last_next;
      end
   end

`ifdef KARATSUBA_ACC_OVF_CHK_EN
   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   logic [CNT_W-1:0] term_cnt;
   logic             ovf_flag;

   // term_cnt holds how many products the current column has already received.
   // It saturates at MAX_TERMS so that any further product keeps flagging.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         term_cnt <= '0;
         ovf_flag <= 1'b0;
      end else if (d_valid) begin
         if (term_cnt == CNT_W'(MAX_TERMS)) begin
            ovf_flag <= 1'b1;
         end
         if (col_end) begin
            term_cnt <= '0;
         end else if (term_cnt != CNT_W'(MAX_TERMS)) begin
            term_cnt <= term_cnt + 1'b1;
         end
      end
   end

   assign ovf = ovf_flag;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_karatsuba_prod_accum.sv
// Self-checking bench for karatsuba_prod_accum: single-column frames from a vector table,
// plus hand-written multi-column, back-to-back, mid-frame reset, overflow and random frames.
module tb_karatsuba_prod_accum;

   localparam int LIMB_W      = 34;
   localparam int PROD_W      = 77;
   localparam int MAX_TERMS   = 4;
   localparam int MUL_LAT     = 5;
   localparam int FLUSH_LIMBS = 2;
   localparam int READY_LOW   = MUL_LAT + FLUSH_LIMBS;
`ifdef KARATSUBA_ACC_OVF_CHK_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              tag_valid;
   logic              tag_col_last;
   logic              tag_frame_last;
   logic              tag_ready;
   logic [PROD_W-1:0] prod;
   logic              limb_valid;
   logic [LIMB_W-1:0] limb;
   logic              limb_last;
   logic              ovf;

   logic [PROD_W-1:0] issue_prod;
   logic [PROD_W-1:0] pipe [MUL_LAT];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [LIMB_W-1:0] cap_limb [$];
   bit                cap_last [$];
   int                cap_cyc  [$];
   int                low_runs [$];
   int                low_len = 0;

   typedef struct {
      int                n;
      logic [PROD_W-1:0] p0;
      logic [PROD_W-1:0] p1;
      logic [LIMB_W-1:0] e0;
      logic [LIMB_W-1:0] e1;
      logic [LIMB_W-1:0] e2;
   } vec_t;

   vec_t vecs [6];

   karatsuba_prod_accum dut (
      .clk            (clk),
      .rst            (rst),
      .tag_valid      (tag_valid),
      .tag_col_last   (tag_col_last),
      .tag_frame_last (tag_frame_last),
      .tag_ready      (tag_ready),
      .prod           (prod),
      .limb_valid     (limb_valid),
      .limb           (limb),
      .limb_last      (limb_last),
      .ovf            (ovf)
   );

   // Clock and a free-running cycle index.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the multiplier: the value issued with a tag appears MUL_LAT cycles later.
   always @(posedge clk) begin
      pipe[0] <= issue_prod;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign prod = pipe[MUL_LAT-1];

   // Output capture and tag_ready low-run measurement, sampled on the falling edge.
   always @(negedge clk) begin
      if (limb_valid === 1'b1) begin
         cap_limb.push_back(limb);
         cap_last.push_back(limb_last);
         cap_cyc.push_back(cyc);
      end
      if (tag_ready === 1'b0) begin
         low_len++;
      end else if (low_len > 0) begin
         low_runs.push_back(low_len);
         low_len = 0;
      end
   end

   // Overall time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operand pair once tag_ready allows it; t returns the acceptance cycle.
   task automatic applyStimulus(input logic [PROD_W-1:0] p, input logic cl, input logic fl, output int t);
      int guard = 0;
      while (tag_ready !== 1'b1 && guard < 50) begin
         step();
         guard++;
      end
      if (guard >= 50) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_wait: tag_ready stayed low for %0d cycles, required high within 50", guard);
      end
      tag_valid      = 1'b1;
      tag_col_last   = cl;
      tag_frame_last = fl;
      issue_prod     = p;
      t              = cyc;
      step();
      tag_valid      = 1'b0;
      tag_col_last   = 1'b0;
      tag_frame_last = 1'b0;
   endtask

   task automatic clear_capture();
      cap_limb.delete();
      cap_last.delete();
      cap_cyc.delete();
      low_runs.delete();
   endtask

   // Wait for n captured limbs within a cycle budget, then let the line settle.
   task automatic wait_limbs(input int n, input int budget);
      int waited = 0;
      while (cap_limb.size() < n && waited < budget) begin
         step();
         waited++;
      end
      if (cap_limb.size() < n) begin
         checks++;
         errors++;
         $display("[TB] FAIL limb_wait: got %0d limbs, expected %0d within %0d cycles", cap_limb.size(), n, budget);
      end
      repeat (4) step();
   endtask

   function automatic logic [LIMB_W-1:0] got_limb(input int k);
      return (k < cap_limb.size()) ? cap_limb[k] : 'x;
   endfunction

   function automatic logic got_last(input int k);
      return (k < cap_last.size()) ? cap_last[k] : 1'bx;
   endfunction

   function automatic int got_cyc(input int k);
      return (k < cap_cyc.size()) ? cap_cyc[k] : -1;
   endfunction

   initial begin
      int t;
      int c0;
      int ncols;
      int nterms;
      int nlimbs;
      logic [95:0]  rnd;
      logic [PROD_W-1:0] p;
      logic [383:0] ref_sum;
      logic [LIMB_W-1:0] exp_limb;

      vecs[0] = '{1, (77'd1 << 76) + 77'd5, 77'd0, 34'd5, 34'd0, 34'd256};
      vecs[1] = '{1, 77'd7, 77'd0, 34'd7, 34'd0, 34'd0};
      vecs[2] = '{2, 77'h3_FFFF_FFFF, 77'h3_FFFF_FFFF, 34'h3_FFFF_FFFE, 34'd1, 34'd0};
      vecs[3] = '{2, {PROD_W{1'b1}}, {PROD_W{1'b1}}, 34'h3_FFFF_FFFE, 34'h3_FFFF_FFFF, 34'd1023};
      vecs[4] = '{1, 77'd0, 77'd0, 34'd0, 34'd0, 34'd0};
      vecs[5] = '{2, 77'h1_2345_6789, 77'd3 << 40, 34'h1_2345_6789, 34'd192, 34'd0};

      rst            = 1'b0;
      tag_valid      = 1'b0;
      tag_col_last   = 1'b0;
      tag_frame_last = 1'b0;
      issue_prod     = '0;

      // Reset values.
      repeat (2) step();
      checkOutput("rst_tag_ready", tag_ready, 1'b1);
      checkOutput("rst_limb_valid", limb_valid, 1'b0);
      checkOutput("rst_limb", limb, '0);
      checkOutput("rst_limb_last", limb_last, 1'b0);
      checkOutput("rst_ovf", ovf, 1'b0);
      rst = 1'b1;
      repeat (MUL_LAT + 2) step();

      // Single-column frames from the table.
      for (int v = 0; v < 6; v++) begin
         clear_capture();
         if (vecs[v].n == 2) begin
            applyStimulus(vecs[v].p0, 1'b0, 1'b0, t);
            applyStimulus(vecs[v].p1, 1'b1, 1'b1, t);
         end else begin
            applyStimulus(vecs[v].p0, 1'b1, 1'b1, t);
         end
         wait_limbs(3, 40);
         checkOutput($sformatf("v%0d_count", v), cap_limb.size(), 3);
         checkOutput($sformatf("v%0d_limb0", v), got_limb(0), vecs[v].e0);
         checkOutput($sformatf("v%0d_limb1", v), got_limb(1), vecs[v].e1);
         checkOutput($sformatf("v%0d_limb2", v), got_limb(2), vecs[v].e2);
         for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("v%0d_last%0d", v, k), got_last(k), (k == 2));
            checkOutput($sformatf("v%0d_cyc%0d", v, k), got_cyc(k), t + MUL_LAT + 1 + k);
         end
         checkOutput($sformatf("v%0d_runs", v), low_runs.size(), 1);
         checkOutput($sformatf("v%0d_ready_low", v), low_runs.size() > 0 ? low_runs[0] : -1, READY_LOW);
      end

      // Two columns: the carry of the first column becomes the second column's limb.
      clear_capture();
      applyStimulus(77'h3_FFFF_FFFF, 1'b0, 1'b0, t);
      applyStimulus(77'h3_FFFF_FFFF, 1'b1, 1'b0, t);
      applyStimulus(77'd0, 1'b1, 1'b1, t);
      wait_limbs(4, 40);
      checkOutput("two_col_count", cap_limb.size(), 4);
      checkOutput("two_col_limb0", got_limb(0), 34'h3_FFFF_FFFE);
      checkOutput("two_col_limb1", got_limb(1), 34'd1);
      checkOutput("two_col_limb2", got_limb(2), 34'd0);
      checkOutput("two_col_limb3", got_limb(3), 34'd0);
      checkOutput("two_col_last2", got_last(2), 1'b0);
      checkOutput("two_col_last3", got_last(3), 1'b1);
      checkOutput("two_col_cyc0", got_cyc(0), t - 1 + MUL_LAT + 1);
      checkOutput("two_col_cyc3", got_cyc(3), t + MUL_LAT + 1 + FLUSH_LIMBS);

      // Back-to-back frames with tag_valid held high: frames are taken every 8 cycles.
      clear_capture();
      c0 = cyc;
      for (int k = 0; k < 2 * (READY_LOW + 1) + 1; k++) begin
         tag_valid      = 1'b1;
         tag_col_last   = 1'b1;
         tag_frame_last = 1'b1;
         issue_prod     = PROD_W'(1000 + cyc);
         step();
      end
      tag_valid      = 1'b0;
      tag_col_last   = 1'b0;
      tag_frame_last = 1'b0;
      wait_limbs(9, 60);
      checkOutput("b2b_count", cap_limb.size(), 9);
      for (int i = 0; i < 9; i++) begin
         int fc;
         fc = c0 + (READY_LOW + 1) * (i / 3);
         exp_limb = (i % 3 == 0) ? LIMB_W'(1000 + fc) : '0;
         checkOutput($sformatf("b2b_limb%0d", i), got_limb(i), exp_limb);
         checkOutput($sformatf("b2b_last%0d", i), got_last(i), (i % 3 == 2));
         checkOutput($sformatf("b2b_cyc%0d", i), got_cyc(i), fc + MUL_LAT + 1 + (i % 3));
      end
      checkOutput("b2b_runs", low_runs.size(), 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("b2b_ready_low%0d", i), i < low_runs.size() ? low_runs[i] : -1, READY_LOW);
      end

      // Reset while three products are in flight during DRAIN; tags offered in reset are ignored.
      clear_capture();
      applyStimulus(77'd1, 1'b1, 1'b0, t);
      applyStimulus(77'd2, 1'b1, 1'b0, t);
      applyStimulus(77'd3, 1'b1, 1'b1, t);
      checkOutput("drain_ready", tag_ready, 1'b0);
      rst            = 1'b0;
      tag_valid      = 1'b1;
      tag_col_last   = 1'b1;
      tag_frame_last = 1'b1;
      issue_prod     = 77'd99;
      step();
      checkOutput("mid_rst_ready", tag_ready, 1'b1);
      checkOutput("mid_rst_limb_valid", limb_valid, 1'b0);
      step();
      rst       = 1'b1;
      tag_valid = 1'b0;
      repeat (15) step();
      checkOutput("post_rst_no_limbs", cap_limb.size(), 0);
      checkOutput("post_rst_ready", tag_ready, 1'b1);
      clear_capture();
      applyStimulus(77'd7, 1'b1, 1'b1, t);
      wait_limbs(3, 40);
      checkOutput("post_rst_count", cap_limb.size(), 3);
      checkOutput("post_rst_limb0", got_limb(0), 34'd7);
      checkOutput("post_rst_limb1", got_limb(1), 34'd0);
      checkOutput("post_rst_limb2", got_limb(2), 34'd0);
      checkOutput("post_rst_last2", got_last(2), 1'b1);
      checkOutput("post_rst_cyc0", got_cyc(0), t + MUL_LAT + 1);

      // Random multi-column frames against a big-integer reference.
      for (int f = 0; f < 4; f++) begin
         clear_capture();
         ref_sum = '0;
         ncols   = $urandom_range(1, 8);
         for (int c = 0; c < ncols; c++) begin
            nterms = $urandom_range(1, MAX_TERMS);
            for (int j = 0; j < nterms; j++) begin
               rnd = {$urandom(), $urandom(), $urandom()};
               p   = rnd[PROD_W-1:0];
               ref_sum = ref_sum + (384'(p) << (LIMB_W * c));
               applyStimulus(p, (j == nterms - 1), (j == nterms - 1) && (c == ncols - 1), t);
            end
         end
         nlimbs = ncols + FLUSH_LIMBS;
         wait_limbs(nlimbs, 60);
         checkOutput($sformatf("rnd%0d_count", f), cap_limb.size(), nlimbs);
         for (int i = 0; i < nlimbs; i++) begin
            checkOutput($sformatf("rnd%0d_limb%0d", f, i), got_limb(i), ref_sum[LIMB_W*i +: LIMB_W]);
            checkOutput($sformatf("rnd%0d_last%0d", f, i), got_last(i), (i == nlimbs - 1));
         end
      end

      // Five terms in one column: overflow when the check is built, data unaffected either way.
      clear_capture();
      checkOutput("ovf_initial", ovf, 1'b0);
      for (int j = 0; j < 5; j++) begin
         applyStimulus(77'd1, (j == 4), (j == 4), t);
      end
      while (cyc < t + MUL_LAT) step();
      checkOutput("ovf_before_fifth", ovf, 1'b0);
      step();
      checkOutput("ovf_after_fifth", ovf, OVF_EN);
      wait_limbs(3, 40);
      checkOutput("ovf_col_count", cap_limb.size(), 3);
      checkOutput("ovf_col_limb0", got_limb(0), 34'd5);
      checkOutput("ovf_col_limb1", got_limb(1), 34'd0);
      checkOutput("ovf_col_last2", got_last(2), 1'b1);
      clear_capture();
      applyStimulus(77'd7, 1'b1, 1'b1, t);
      wait_limbs(3, 40);
      checkOutput("ovf_sticky", ovf, OVF_EN);
      checkOutput("ovf_next_limb0", got_limb(0), 34'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/karatsuba_prod_accum.md
# karatsuba_prod_accum

Column accumulator directly downstream of the 34x43 Karatsuba multiplier. It takes the 77-bit products the multiplier produces at throughput 1 and sums all products belonging to one output column. Per column it emits one 34-bit limb of a multi-precision product and carries the rest forward. At frame end it flushes the carry as extra limbs. Operand tags travel through an internal delay line matched to the multiplier latency, so upstream tags operand pairs at issue time.

## Interface
- LIMB_W, 34, output limb width
- PROD_W, 77, multiplier product width
- MAX_TERMS, 4, maximum products summed per column
- MUL_LAT, 5, multiplier latency in cycles (sum of its FF_* parameters, min 1)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- tag_valid  input  1  operand pair issued to the multiplier this cycle
- tag_col_last  input  1  this pair is the last term of its column
- tag_frame_last  input  1  this pair is the last term of the frame (implies tag_col_last)
- tag_ready  output  1  upstream may issue only when high
- prod  input  PROD_W  multiplier output C, unsigned
- limb_valid  output  1  limb output valid, one-cycle strobe, no backpressure
- limb  output  LIMB_W  emitted limb, least significant first
- limb_last  output  1  final limb of frame
- ovf  output  1  sticky column-overflow flag

## Operation
- Constants:
  - ACC_W = PROD_W + clog2(MAX_TERMS) + 1, which is 80 at defaults.
  - FLUSH_LIMBS = ceil((ACC_W-LIMB_W)/LIMB_W), which is 2 at defaults.
- Tag acceptance: a tag is accepted when tag_valid & tag_ready.
  - Accepted tags {valid, col_last, frame_last} enter a MUL_LAT-deep delay line.
  - Tags offered while tag_ready is low are dropped. Their products are ignored.
- Delayed valid high in cycle k means prod in cycle k belongs to that tag.
- Accumulate: acc_n = acc + zero-extend(prod), computed modulo 2^ACC_W.
  - Not col_last: acc <= acc_n and the term counter increments.
  - col_last: emit limb = acc_n[LIMB_W-1:0], then acc <= acc_n >> LIMB_W and the term counter clears.
- States:
  - ACCUM: tag_ready=1. Accepting a frame_last tag moves to DRAIN on the next cycle.
  - DRAIN: tag_ready=0. Products of earlier tags continue to accumulate and emit normally. When the delayed frame_last product arrives, its column limb is emitted and the state moves to FLUSH with flush counter 0.
  - FLUSH: tag_ready=0. Each cycle it emits acc[LIMB_W-1:0] and shifts acc right by LIMB_W. The limb with counter FLUSH_LIMBS-1 has limb_last=1, clears acc, and returns to ACCUM.
- Flush limbs are emitted even when zero. A frame always produces columns + FLUSH_LIMBS limbs.
- A delayed valid with frame_last but not col_last is treated as col_last.
- Reset mid-frame: the delay line, acc, counters and state clear immediately. In-flight products are lost. No partial limb_last is emitted.

## Timing
- Reset values: tag_ready=1 (state ACCUM), limb_valid=0, limb=0, limb_last=0, ovf=0. Tags presented while rst is low are ignored.
- Latency: a col_last tag accepted in cycle t produces its limb (registered output) in cycle t+MUL_LAT+1.
- Frame end: a frame_last tag accepted in cycle t produces:
  - the column limb in cycle t+MUL_LAT+1,
  - flush limbs in cycles t+MUL_LAT+2 .. t+MUL_LAT+1+FLUSH_LIMBS, with limb_last on the final one.
- tag_ready is low from t+1 through t+MUL_LAT+FLUSH_LIMBS, i.e. 7 cycles at defaults. It is high again in the limb_last cycle.
- Steady state within a frame: one product per cycle, no bubbles.

## Configuration
- KARATSUBA_ACC_OVF_CHK_EN defined:
  - A per-column term counter compares against MAX_TERMS.
  - A column receiving more than MAX_TERMS valid products sets ovf the cycle after the offending product.
  - ovf is sticky until reset. Data output is unaffected.
- Undefined: no counter comparator is built, and ovf is tied to 0.

## Structure
- Shared package holds LIMB_W/PROD_W defaults, ACC_W and FLUSH_LIMBS derivation functions, and the state enum {ACCUM, DRAIN, FLUSH}.
- One sub-module: karatsuba_tag_delay, a parameterised MUL_LAT-deep shift register of 3-bit tags with async active-low reset to 0.

## Test plan
- Single-term frame, prod=2^76+5, frame_last → limbs 5, 0, 256 in consecutive cycles, limb_last on 256, first limb at t+6.
- Two terms 2^34-1, 2^34-1 in one column, then frame_last column with prod=0 → limbs 0x3_FFFF_FFFE, 1, 0, 0 (last).
- Back-to-back frames, tag_valid held high → tag_ready low exactly 7 cycles after each frame_last. Tags offered during that window are dropped, and the next frame's limbs are correct.
- rst pulsed low while the DRAIN state holds 3 products in flight → no limb_valid after reset. A fresh frame of prod=7 yields 7, 0, 0.
- With KARATSUBA_ACC_OVF_CHK_EN, five terms of 1 in one column → ovf rises after the fifth and stays high. The limb equals 5.
- Random frames of 1-4 terms per column, 1-8 columns → the concatenated limbs equal the reference big-integer sum of shifted products.
